// File: rtl/universal_sync_fifo_if.sv
// Handshake and data bundle between a producer/consumer and the FIFO.
// The master side drives requests and write data; the slave (FIFO) side
// returns registered read data and the occupancy flags.
interface universal_sync_fifo_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  cs;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  empty;
   logic                  full;

   modport master (
      output cs, wr_en, rd_en, data_in,
      input  data_out, empty, full
   );

   modport slave (
      input  cs, wr_en, rd_en, data_in,
      output data_out, empty, full
   );
endinterface : universal_sync_fifo_if

// File: rtl/universal_sync_fifo.sv
// Single-clock FIFO with chip-select gated ports, registered read data and
// combinational full/empty flags. Pointers carry one extra wrap bit so that
// full and empty are distinguishable when the index bits match.
module universal_sync_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   universal_sync_fifo_if.slave bus
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic empty;
   logic full;
   logic wr_accept;
   logic rd_accept;

   // Flags come straight from the pointer registers, so they reflect an
   // accepted transfer in the cycle after its edge.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                  (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

   // Each port is judged against the pre-edge flags; a write into an empty
   // FIFO therefore never falls through to data_out in the same cycle.
   assign wr_accept = bus.cs & bus.wr_en & ~full;
   assign rd_accept = bus.cs & bus.rd_en & ~empty;

   assign bus.data_out = data_out_q;
   assign bus.empty    = empty;
   assign bus.full     = full;

   // Next-state for pointers and read data register.
   always_comb begin
      // NOTE: every output gets a hold default first so no path leaves it unassigned (no latch).
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_accept) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         data_out_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
   end

   // Control state: pointers and registered read data, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage array write port.
   // NOTE: the array has no reset; its contents are unreachable until written, and a reset would block RAM inference.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.data_in;
      end
   end

endmodule : universal_sync_fifo

// File: tb/tb_universal_sync_fifo.sv
// Directed self-checking bench for universal_sync_fifo (depth 8, width 32).
module tb_universal_sync_fifo;

   localparam int DEPTH = 8;
   localparam int DW    = 32;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   universal_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

   universal_sync_fifo #(
      .FIFO_DEPTH (DEPTH),
      .DATA_WIDTH (DW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the given request; inputs return to idle afterwards
   // and the caller samples outputs 1 ns after the edge.
   task automatic op(input logic cs, input logic wr, input logic rd, input logic [DW-1:0] din);
      bus.cs      = cs;
      bus.wr_en   = wr;
      bus.rd_en   = rd;
      bus.data_in = din;
      @(posedge clk);
      #1;
      bus.cs      = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;
   endtask

   task automatic wr(input logic [DW-1:0] din);
      op(1'b1, 1'b1, 1'b0, din);
   endtask

   task automatic rd();
      op(1'b1, 1'b0, 1'b1, '0);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      bus.cs      = 1'b0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.data_in = '0;

      // Reset state, visible before any clock edge.
      #2;
      check("rst_empty", DW'(bus.empty), 1);
      check("rst_full", DW'(bus.full), 0);
      check("rst_dout", bus.data_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Basic write 1, 10, 100 then read back.
      wr(32'd1);
      check("w1_empty", DW'(bus.empty), 0);
      wr(32'd10);
      wr(32'd100);
      rd();
      check("r1_data", bus.data_out, 32'd1);
      rd();
      check("r2_data", bus.data_out, 32'd10);
      rd();
      check("r3_data", bus.data_out, 32'd100);
      check("r3_empty", DW'(bus.empty), 1);

      // Read while empty: ignored.
      rd();
      check("rempty_dout", bus.data_out, 32'd100);
      check("rempty_empty", DW'(bus.empty), 1);

      // Alternate write/read; pointers start at 3 so this wraps past entry 7.
      for (int i = 0; i < 8; i++) begin
         wr(DW'(1) << i);
         check($sformatf("alt_w%0d_empty", i), DW'(bus.empty), 0);
         rd();
         check($sformatf("alt_r%0d_data", i), bus.data_out, DW'(1) << i);
         check($sformatf("alt_r%0d_empty", i), DW'(bus.empty), 1);
      end

      // Fill to full; the ninth write is dropped.
      for (int i = 0; i < 9; i++) begin
         wr(DW'(1) << i);
         if (i == 6) check("fill7_full", DW'(bus.full), 0);
         if (i >= 7) check($sformatf("fill%0d_full", i + 1), DW'(bus.full), 1);
      end
      for (int i = 0; i < 8; i++) begin
         rd();
         check($sformatf("drain%0d_data", i), bus.data_out, DW'(1) << i);
         if (i == 0) check("drain0_full", DW'(bus.full), 0);
      end
      check("drain_empty", DW'(bus.empty), 1);

      // Simultaneous write/read with 4 entries held.
      for (int i = 0; i < 4; i++) wr(32'hA0 + DW'(i));
      op(1'b1, 1'b1, 1'b1, 32'hAA);
      check("sim_half_data", bus.data_out, 32'hA0);
      check("sim_half_empty", DW'(bus.empty), 0);
      check("sim_half_full", DW'(bus.full), 0);
      rd();
      check("sim_half_r1", bus.data_out, 32'hA1);
      rd();
      check("sim_half_r2", bus.data_out, 32'hA2);
      rd();
      check("sim_half_r3", bus.data_out, 32'hA3);
      rd();
      check("sim_half_r4", bus.data_out, 32'hAA);
      check("sim_half_end_empty", DW'(bus.empty), 1);

      // Simultaneous write/read at full: only the read happens.
      for (int i = 0; i < 8; i++) wr(32'hB0 + DW'(i));
      check("sim_full_pre", DW'(bus.full), 1);
      op(1'b1, 1'b1, 1'b1, 32'hBB);
      check("sim_full_data", bus.data_out, 32'hB0);
      check("sim_full_full", DW'(bus.full), 0);
      for (int i = 1; i < 8; i++) begin
         rd();
         check($sformatf("sim_full_r%0d", i), bus.data_out, 32'hB0 + DW'(i));
      end
      check("sim_full_end_empty", DW'(bus.empty), 1);

      // Simultaneous write/read at empty: only the write, no fall-through.
      op(1'b1, 1'b1, 1'b1, 32'hCC);
      check("sim_empty_dout", bus.data_out, 32'hB7);
      check("sim_empty_empty", DW'(bus.empty), 0);
      rd();
      check("sim_empty_r", bus.data_out, 32'hCC);
      check("sim_empty_end", DW'(bus.empty), 1);

      // cs low blocks both ports.
      wr(32'hD0);
      op(1'b0, 1'b1, 1'b1, 32'hDD);
      check("cs0_dout", bus.data_out, 32'hCC);
      check("cs0_empty", DW'(bus.empty), 0);
      rd();
      check("cs0_r", bus.data_out, 32'hD0);
      check("cs0_end_empty", DW'(bus.empty), 1);

      // Asynchronous reset mid-stream, between clock edges.
      wr(32'hE0);
      wr(32'hE1);
      wr(32'hE2);
      rd();
      check("prerst_dout", bus.data_out, 32'hE0);
      #2;
      rst = 1'b1;
      #1;
      check("arst_empty", DW'(bus.empty), 1);
      check("arst_full", DW'(bus.full), 0);
      check("arst_dout", bus.data_out, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      wr(32'h55);
      rd();
      check("postrst_r", bus.data_out, 32'h55);
      check("postrst_empty", DW'(bus.empty), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_universal_sync_fifo
